// File: rtl/fake_psx_pad.sv
// fake_psx_pad: device-side emulator of a PlayStation controller.
// Answers host polls on the psx_clk/cmd/att bus with the standard poll frame.
// The frame is FF, ID, 5A, buttons lo, buttons hi. Every byte except the last
// is followed by an active-low ack pulse.
// Optional feature macro FAKE_PSX_PAD_ANALOG_EN: adds the sticks input, changes
// the ID to 73 and extends the frame to 9 bytes (RX, RY, LX, LY appended).
// Ports:
//   clk      - system clock, at least 8x psx_clk
//   rst      - synchronous active-high reset
//   psx_clk  - host bus clock (idle high, asynchronous to clk)
//   cmd      - host-to-pad serial data, LSB first
//   att      - active-low select from host
//   buttons  - active-low button state, latched at att fall
//   sticks   - {LY, LX, RY, RX}, analog build only
//   data     - pad-to-host serial data, idle 1
//   ack      - active-low acknowledge, idle 1
//   rx_byte  - last complete command byte
//   rx_valid - one-cycle pulse when rx_byte updates
module fake_psx_pad #(
  parameter int unsigned ACK_DELAY = 20,
  parameter int unsigned ACK_LEN   = 4,
  parameter logic [7:0]  PAD_ID    = 8'h41
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic        att,
  input  logic [15:0] buttons,
`ifdef FAKE_PSX_PAD_ANALOG_EN
  input  logic [31:0] sticks,
`endif
  output logic        data,
  output logic        ack,
  output logic [7:0]  rx_byte,
  output logic        rx_valid
);

`ifdef FAKE_PSX_PAD_ANALOG_EN
  // Nine bytes need a 4-bit index.
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;
  localparam logic [7:0] ID_BYTE = 8'h73;
`else
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = 3'd4;
  localparam logic [7:0] ID_BYTE = PAD_ID;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_XFER, ST_ACK_WAIT, ST_ACK_PULSE, ST_DONE, ST_IGNORE
  } state_t;

  state_t           state_r;
  logic             psx_meta_r, psx_sync_r, psx_prev_r;
  logic             att_meta_r, att_sync_r, att_prev_r;
  logic             cmd_meta_r, cmd_sync_r;
  logic [3:0]       bit_cnt_r;
  logic [IDX_W-1:0] byte_idx_r;
  logic [7:0]       rx_shift_r;
  logic [15:0]      btn_lat_r;
  logic [15:0]      dly_cnt_r;
`ifdef FAKE_PSX_PAD_ANALOG_EN
  logic [31:0]      stk_lat_r;
`endif

  logic             psx_rise_s, psx_fall_s, att_rise_s, att_fall_s;
  logic [7:0]       rx_next_s;
  logic             byte_done_s;
  logic [3:0]       bit_cnt_inc_s;
  logic [IDX_W-1:0] byte_idx_inc_s;
  logic [7:0]       tx_byte_s;

  assign psx_rise_s  = psx_sync_r & ~psx_prev_r;
  assign psx_fall_s  = ~psx_sync_r & psx_prev_r;
  assign att_rise_s  = att_sync_r & ~att_prev_r;
  assign att_fall_s  = ~att_sync_r & att_prev_r;
  assign rx_next_s   = {cmd_sync_r, rx_shift_r[7:1]};
  // A rise while seven bits are already counted is the eighth bit.
  assign byte_done_s = psx_rise_s && (bit_cnt_r == 4'd7);
  assign bit_cnt_inc_s  = (bit_cnt_r == 4'hF) ? bit_cnt_r : bit_cnt_r + 4'd1;
  assign byte_idx_inc_s = (byte_idx_r == {IDX_W{1'b1}}) ? byte_idx_r
                                                         : byte_idx_r + IDX_W'(1);

  // Response byte selected by the current byte index from the latched state.
  always_comb begin
    tx_byte_s = 8'hFF;
    case (byte_idx_r)
      IDX_W'(0): tx_byte_s = 8'hFF;
      IDX_W'(1): tx_byte_s = ID_BYTE;
      IDX_W'(2): tx_byte_s = 8'h5A;
      IDX_W'(3): tx_byte_s = btn_lat_r[7:0];
      IDX_W'(4): tx_byte_s = btn_lat_r[15:8];
`ifdef FAKE_PSX_PAD_ANALOG_EN
      IDX_W'(5): tx_byte_s = stk_lat_r[7:0];
      IDX_W'(6): tx_byte_s = stk_lat_r[15:8];
      IDX_W'(7): tx_byte_s = stk_lat_r[23:16];
      IDX_W'(8): tx_byte_s = stk_lat_r[31:24];
`endif
      default:   tx_byte_s = 8'hFF;
    endcase
  end

  // Two-flop synchronizers plus a delayed copy for edge detection.
  // Idle-high lines reset to 1 so that leaving reset creates no false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      psx_meta_r <= 1'b1;
      psx_sync_r <= 1'b1;
      psx_prev_r <= 1'b1;
      att_meta_r <= 1'b1;
      att_sync_r <= 1'b1;
      att_prev_r <= 1'b1;
      cmd_meta_r <= 1'b0;
      cmd_sync_r <= 1'b0;
    end else begin
      psx_meta_r <= psx_clk;
      psx_sync_r <= psx_meta_r;
      psx_prev_r <= psx_sync_r;
      att_meta_r <= att;
      att_sync_r <= att_meta_r;
      att_prev_r <= att_sync_r;
      cmd_meta_r <= cmd;
      cmd_sync_r <= cmd_meta_r;
    end
  end

  // Protocol FSM with registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      data       <= 1'b1;
      ack        <= 1'b1;
      rx_byte    <= 8'h00;
      rx_valid   <= 1'b0;
      bit_cnt_r  <= 4'd0;
      byte_idx_r <= '0;
      rx_shift_r <= 8'h00;
      btn_lat_r  <= 16'hFFFF;
      dly_cnt_r  <= 16'd0;
`ifdef FAKE_PSX_PAD_ANALOG_EN
      stk_lat_r  <= 32'h0000_0000;
`endif
    end else begin
      rx_valid <= 1'b0;
      if (att_rise_s) begin
        // Deselect aborts everything, including a partial byte or an ack.
        data       <= 1'b1;
        ack        <= 1'b1;
        bit_cnt_r  <= 4'd0;
        byte_idx_r <= '0;
        state_r    <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            data <= 1'b1;
            ack  <= 1'b1;
            if (att_fall_s) begin
              btn_lat_r  <= buttons;
`ifdef FAKE_PSX_PAD_ANALOG_EN
              stk_lat_r  <= sticks;
`endif
              byte_idx_r <= '0;
              bit_cnt_r  <= 4'd0;
              state_r    <= ST_XFER;
            end
          end
          ST_XFER: begin
            if (psx_fall_s) begin
              data <= tx_byte_s[bit_cnt_r[2:0]];
            end
            if (psx_rise_s) begin
              rx_shift_r <= rx_next_s;
              if (byte_done_s) begin
                rx_byte   <= rx_next_s;
                rx_valid  <= 1'b1;
                bit_cnt_r <= 4'd0;
                data      <= 1'b1;
                dly_cnt_r <= 16'd0;
                if (byte_idx_r == IDX_W'(0) && rx_next_s != 8'h01) begin
                  state_r <= ST_IGNORE;
                end else if (byte_idx_r == IDX_W'(1) && rx_next_s != 8'h42) begin
                  state_r <= ST_IGNORE;
                end else if (byte_idx_r == LAST_IDX) begin
                  state_r <= ST_DONE;
                end else begin
                  state_r <= ST_ACK_WAIT;
                end
              end else begin
                bit_cnt_r <= bit_cnt_inc_s;
              end
            end
          end
          ST_ACK_WAIT: begin
            // Bus clock edges here are a host violation and are dropped.
            if (dly_cnt_r == 16'(ACK_DELAY - 1)) begin
              ack       <= 1'b0;
              dly_cnt_r <= 16'd0;
              state_r   <= ST_ACK_PULSE;
            end else begin
              dly_cnt_r <= dly_cnt_r + 16'd1;
            end
          end
          ST_ACK_PULSE: begin
            if (dly_cnt_r == 16'(ACK_LEN - 1)) begin
              ack        <= 1'b1;
              byte_idx_r <= byte_idx_inc_s;
              state_r    <= ST_XFER;
            end else begin
              dly_cnt_r <= dly_cnt_r + 16'd1;
            end
          end
          ST_DONE: begin
            data <= 1'b1;
            ack  <= 1'b1;
          end
          ST_IGNORE: begin
            // Still receive bytes so the host sees rx_valid, but never answer.
            data <= 1'b1;
            ack  <= 1'b1;
            if (psx_rise_s) begin
              rx_shift_r <= rx_next_s;
              if (byte_done_s) begin
                rx_byte   <= rx_next_s;
                rx_valid  <= 1'b1;
                bit_cnt_r <= 4'd0;
              end else begin
                bit_cnt_r <= bit_cnt_inc_s;
              end
            end
          end
          default: begin
            data    <= 1'b1;
            ack     <= 1'b1;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fake_psx_pad.sv
// Self-checking bench for fake_psx_pad. A host model drives psx_clk/cmd/att.
// While it drives, it records the cycle-indexed outputs that the pad must show
// in timeline maps. A per-cycle compare process checks data, ack, rx_valid and
// rx_byte against those maps.
module tb_fake_psx_pad;
`ifdef FAKE_PSX_PAD_ANALOG_EN
  localparam int NB = 9;
  localparam logic [7:0] ID_BYTE = 8'h73;
`else
  localparam int NB = 5;
  localparam logic [7:0] ID_BYTE = 8'h41;
`endif

  logic clk = 1'b0;
  logic rst, psx_clk, cmd, att;
  logic [15:0] buttons;
  logic [31:0] sticks;
  logic data, ack, rx_valid;
  logic [7:0] rx_byte;

  fake_psx_pad #(.ACK_DELAY(20), .ACK_LEN(4), .PAD_ID(8'h41)) dut (
    .clk(clk), .rst(rst), .psx_clk(psx_clk), .cmd(cmd), .att(att),
    .buttons(buttons),
`ifdef FAKE_PSX_PAD_ANALOG_EN
    .sticks(sticks),
`endif
    .data(data), .ack(ack), .rx_byte(rx_byte), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected timeline, keyed by cycle number.
  bit         ack_low_m[int];
  bit         valid_m[int];
  bit         data_m[int];
  logic [7:0] rxb_m[int];

  bit         exp_data = 1'b1;
  logic [7:0] exp_rxb = 8'h00;
  bit         chk_en = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
  int         ack_low_cnt = 0;
  int         valid_cnt = 0;

  // Host-side frame model.
  int         mode = 0;          // 0 idle, 1 answering, 2 ignoring, 3 done
  int         midx = 0;
  logic [7:0] frame[NB];
  logic [7:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (data_m.exists(cyc)) exp_data = data_m[cyc];
      if (rxb_m.exists(cyc)) exp_rxb = rxb_m[cyc];
      check("data", {31'd0, data}, {31'd0, exp_data});
      check("ack", {31'd0, ack}, ack_low_m.exists(cyc) ? 32'd0 : 32'd1);
      check("rx_valid", {31'd0, rx_valid}, valid_m.exists(cyc) ? 32'd1 : 32'd0);
      check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_rxb});
      if (ack === 1'b0) ack_low_cnt++;
      if (rx_valid === 1'b1) valid_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cancel_from(input int c);
    int ks[$];
    ks = {};
    foreach (ack_low_m[k]) if (k >= c) ks.push_back(k);
    foreach (ks[i]) ack_low_m.delete(ks[i]);
    ks = {};
    foreach (valid_m[k]) if (k >= c) ks.push_back(k);
    foreach (ks[i]) valid_m.delete(ks[i]);
    ks = {};
    foreach (data_m[k]) if (k >= c) ks.push_back(k);
    foreach (ks[i]) data_m.delete(ks[i]);
    ks = {};
    foreach (rxb_m[k]) if (k >= c) ks.push_back(k);
    foreach (ks[i]) rxb_m.delete(ks[i]);
  endtask

  task automatic att_fall();
    @(negedge clk);
    att = 1'b0;
    frame[0] = 8'hFF;
    frame[1] = ID_BYTE;
    frame[2] = 8'h5A;
    frame[3] = buttons[7:0];
    frame[4] = buttons[15:8];
`ifdef FAKE_PSX_PAD_ANALOG_EN
    frame[5] = sticks[7:0];
    frame[6] = sticks[15:8];
    frame[7] = sticks[23:16];
    frame[8] = sticks[31:24];
`endif
    mode = 1;
    midx = 0;
    got_q = {};
    tick(6);
  endtask

  // Deselect: 2 sync flops + 1 register, so idle outputs from raw+3.
  task automatic att_rise();
    int n;
    @(negedge clk);
    att = 1'b1;
    n = cyc;
    cancel_from(n + 3);
    data_m[n + 3] = 1'b1;
    mode = 0;
    tick(6);
  endtask

  task automatic do_reset(input int cycles);
    int n;
    @(negedge clk);
    rst = 1'b1;
    n = cyc;
    cancel_from(n + 1);
    data_m[n + 1] = 1'b1;
    rxb_m[n + 1] = 8'h00;
    mode = 0;
    tick(1);
    check("rst_data", {31'd0, data}, 32'd1);
    check("rst_ack", {31'd0, ack}, 32'd1);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_byte", {24'd0, rx_byte}, 32'h00);
    att = 1'b1;
    psx_clk = 1'b1;
    cmd = 1'b0;
    tick(cycles);
    rst = 1'b0;
    tick(6);
  endtask

  // Send nbits of b (LSB first), h clk cycles per half period.
  // abort_ack raises att in the middle of the ack pulse after this byte.
  task automatic send_bits(input logic [7:0] b, input int nbits, input int h, input bit abort_ack);
    int n;
    logic [7:0] smp;
    smp = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      psx_clk = 1'b0;
      cmd = b[i];
      n = cyc;
      if (mode == 1) data_m[n + 3] = frame[midx][i];
      tick(h - 1);
      @(negedge clk);
      smp[i] = data;
      psx_clk = 1'b1;
      n = cyc;
      if (i == 7) begin
        if (mode == 1 || mode == 2) begin
          valid_m[n + 3] = 1'b1;
          rxb_m[n + 3] = b;
        end
        if (mode == 1) begin
          data_m[n + 3] = 1'b1;
          got_q.push_back(smp);
          if ((midx == 0 && b != 8'h01) || (midx == 1 && b != 8'h42)) begin
            mode = 2;
          end else if (midx == NB - 1) begin
            mode = 3;
          end else begin
            // Detected at n+3; ack low 20 cycles later for 4 cycles.
            for (int k = 23; k <= 26; k++) ack_low_m[n + k] = 1'b1;
            midx++;
            if (abort_ack) begin
              tick(21);
              att_rise();
              return;
            end
            tick(28);
          end
        end
      end
      tick(h - 1);
    end
  endtask

  task automatic pin_frame(input string name, input logic [7:0] exp[NB], input int cnt);
    check({name, "_len"}, got_q.size(), cnt);
    for (int i = 0; i < cnt && i < got_q.size(); i++)
      check(name, {24'd0, got_q[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    logic [7:0] pin_exp[NB];
    logic [7:0] b;
    int a0, v0, h, nb;
`ifdef FAKE_PSX_PAD_ANALOG_EN
    pin_exp = '{8'hFF, 8'h73, 8'h5A, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h7F, 8'h80};
`else
    pin_exp = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFF};
`endif
    rst = 1'b1; att = 1'b1; psx_clk = 1'b1; cmd = 1'b0;
    buttons = 16'hFFFF; sticks = 32'h80_7F_00_FF;
    tick(5);
    check("reset_data", {31'd0, data}, 32'd1);
    check("reset_ack", {31'd0, ack}, 32'd1);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_byte", {24'd0, rx_byte}, 32'h00);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(4);

    // Full poll with literal expectations.
    buttons = 16'hFFFE;
    a0 = ack_low_cnt; v0 = valid_cnt;
    att_fall();
    send_bits(8'h01, 8, 6, 1'b0);
    send_bits(8'h42, 8, 6, 1'b0);
    for (int j = 2; j < NB; j++) send_bits(8'h00, 8, 6, 1'b0);
    att_rise();
    pin_frame("poll_byte", pin_exp, NB);
    check("poll_ack_cycles", ack_low_cnt - a0, 4 * (NB - 1));
    check("poll_valid_count", valid_cnt - v0, NB);

    // Wrong address: FF then silence, no ack.
    a0 = ack_low_cnt; v0 = valid_cnt;
    att_fall();
    send_bits(8'h81, 8, 5, 1'b0);
    for (int j = 0; j < 3; j++) send_bits(8'h00, 8, 5, 1'b0);
    att_rise();
    check("wrong_addr_ack_cycles", ack_low_cnt - a0, 0);
    check("wrong_addr_valid_count", valid_cnt - v0, 4);
    check("wrong_addr_byte0", {24'd0, got_q[0]}, 32'hFF);

    // Deselect after 3 bits of byte 2.
    v0 = valid_cnt;
    att_fall();
    send_bits(8'h01, 8, 4, 1'b0);
    send_bits(8'h42, 8, 4, 1'b0);
    send_bits(8'h00, 3, 4, 1'b0);
    att_rise();
    check("partial_valid_count", valid_cnt - v0, 2);

    // Deselect in the middle of the first ack pulse.
    a0 = ack_low_cnt;
    att_fall();
    send_bits(8'h01, 8, 6, 1'b1);
    check("ack_abort_cycles", ack_low_cnt - a0, 2);

    // Reset in the middle of byte 3.
    buttons = 16'h1234;
    att_fall();
    send_bits(8'h01, 8, 5, 1'b0);
    send_bits(8'h42, 8, 5, 1'b0);
    send_bits(8'h00, 8, 5, 1'b0);
    send_bits(8'h00, 4, 5, 1'b0);
    do_reset(3);

    // Randomized polls; buttons/sticks change after latching.
    for (int f = 0; f < 14; f++) begin
      buttons = 16'($urandom);
      sticks = $urandom;
      h = $urandom_range(7, 4);
      nb = $urandom_range(NB + 1, 1);
      att_fall();
      buttons = 16'($urandom);
      sticks = $urandom;
      for (int j = 0; j < nb; j++) begin
        b = 8'($urandom);
        if (j == 0 && $urandom_range(9, 0) != 0) b = 8'h01;
        if (j == 1 && $urandom_range(9, 0) != 0) b = 8'h42;
        send_bits(b, 8, h, 1'b0);
      end
      att_rise();
    end

    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
